// File: rtl/bus_router.sv
// bus_router: decodes CPU accesses into NREG address regions, inserts per-region
// wait states and returns read data (or OPEN_BUS when unmapped) with a one-cycle
// cpu_ready completion pulse.
//
// Ports:
//   clock, reset             system clock, asynchronous active-high reset
//   cpu_req/address/we/wdata CPU request strobe and payload, sampled in IDLE
//   cpu_ready, cpu_rdata     completion pulse and held read data
//   reg_sel                  one-hot region select, held from acceptance
//   reg_address, reg_wdata   latched access address and write data
//   reg_we                   per-region write strobe, pulsed in DONE
//   reg_rdata                per-region read data, region i at [i*8 +: 8]
//
// Optional feature (macro BUS_ROUTER_FAULT_EN): adds fault_clear, fault and
// fault_addr, which capture the first unmapped access or read-only write.
module bus_router #(
    parameter int unsigned         AW       = 20,
    parameter int unsigned         NREG     = 4,
    parameter logic [NREG*AW-1:0]  REG_BASE = '0,
    parameter logic [NREG*AW-1:0]  REG_MASK = '0,
    parameter logic [NREG*4-1:0]   REG_WAIT = '0,
    parameter logic [NREG-1:0]     REG_RO   = '0,
    parameter logic [7:0]          OPEN_BUS = 8'hFF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [AW-1:0]     cpu_address,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ready,
    output logic [7:0]        cpu_rdata,
    output logic [NREG-1:0]   reg_sel,
    output logic [AW-1:0]     reg_address,
    output logic [7:0]        reg_wdata,
    output logic [NREG-1:0]   reg_we,
    input  logic [NREG*8-1:0] reg_rdata
`ifdef BUS_ROUTER_FAULT_EN
    ,
    input  logic              fault_clear,
    output logic              fault,
    output logic [AW-1:0]     fault_addr
`endif
);

    localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [3:0]      wait_cnt;
    logic            hit_q;
    logic            we_q;
    logic [IW-1:0]   idx_q;

    logic            hit_c;
    logic [IW-1:0]   hit_idx_c;
    logic [NREG-1:0] sel_c;
    logic [3:0]      wait_c;

    // Address decode; scanning from the top down lets the lowest match win.
    always_comb begin
        hit_c     = 1'b0;
        hit_idx_c = '0;
        for (int i = int'(NREG) - 1; i >= 0; i--) begin
            if ((cpu_address & REG_MASK[i*AW +: AW]) ==
                (REG_BASE[i*AW +: AW] & REG_MASK[i*AW +: AW])) begin
                hit_c     = 1'b1;
                hit_idx_c = IW'(i);
            end
        end
        sel_c  = hit_c ? (NREG'(1) << hit_idx_c) : '0;
        wait_c = hit_c ? REG_WAIT[32'(hit_idx_c)*4 +: 4] : 4'd0;
    end

    // Access sequencer: IDLE accepts, WAIT burns wait states, DONE completes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            hit_q       <= 1'b0;
            we_q        <= 1'b0;
            idx_q       <= '0;
            cpu_ready   <= 1'b0;
            cpu_rdata   <= 8'd0;
            reg_sel     <= '0;
            reg_address <= '0;
            reg_wdata   <= 8'd0;
            reg_we      <= '0;
        end else begin
            cpu_ready <= 1'b0;
            reg_we    <= '0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        reg_address <= cpu_address;
                        reg_wdata   <= cpu_wdata;
                        we_q        <= cpu_we;
                        hit_q       <= hit_c;
                        idx_q       <= hit_idx_c;
                        reg_sel     <= sel_c;
                        wait_cnt    <= wait_c;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        cpu_rdata <= (hit_q && !we_q) ? reg_rdata[32'(idx_q)*8 +: 8]
                                                      : OPEN_BUS;
                        cpu_ready <= 1'b1;
                        // Strobe lands in DONE, together with cpu_ready.
                        if (we_q && hit_q && !REG_RO[idx_q]) begin
                            reg_we <= reg_sel;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef BUS_ROUTER_FAULT_EN
    logic fault_event_c;

    assign fault_event_c = (state == IDLE) && cpu_req &&
                           (!hit_c || (cpu_we && REG_RO[hit_idx_c]));

    // Sticky fault capture; a new event beats a same-cycle clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fault      <= 1'b0;
            fault_addr <= '0;
        end else if (fault_event_c && (!fault || fault_clear)) begin
            fault      <= 1'b1;
            fault_addr <= cpu_address;
        end else if (fault_clear && !fault_event_c) begin
            fault      <= 1'b0;
            fault_addr <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_bus_router.sv
// Directed bench for bus_router: region decode, wait-state latency, write
// strobes, read-only suppression, open-bus reads, ignored requests and reset
// abort. Region map used here:
//   r0 base 0x00000 mask 0xC0000 wait 0
//   r1 base 0x00000 mask 0xFFF00 wait 1 (overlaps r0)
//   r2 base 0x40000 mask 0xC0000 wait 3
//   r3 base 0xC0000 mask 0xC0000 wait 1 read-only
//   0x80000..0xBFFFF unmapped
module tb_bus_router;

    localparam int unsigned AW   = 20;
    localparam int unsigned NREG = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              cpu_req;
    logic [AW-1:0]     cpu_address;
    logic              cpu_we;
    logic [7:0]        cpu_wdata;
    logic              cpu_ready;
    logic [7:0]        cpu_rdata;
    logic [NREG-1:0]   reg_sel;
    logic [AW-1:0]     reg_address;
    logic [7:0]        reg_wdata;
    logic [NREG-1:0]   reg_we;
    logic [NREG*8-1:0] reg_rdata;
`ifdef BUS_ROUTER_FAULT_EN
    logic              fault_clear;
    logic              fault;
    logic [AW-1:0]     fault_addr;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    bus_router #(
        .AW       (AW),
        .NREG     (NREG),
        .REG_BASE ({20'hC0000, 20'h40000, 20'h00000, 20'h00000}),
        .REG_MASK ({20'hC0000, 20'hC0000, 20'hFFF00, 20'hC0000}),
        .REG_WAIT (16'h1310),
        .REG_RO   (4'b1000),
        .OPEN_BUS (8'hFF)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_address (cpu_address),
        .cpu_we      (cpu_we),
        .cpu_wdata   (cpu_wdata),
        .cpu_ready   (cpu_ready),
        .cpu_rdata   (cpu_rdata),
        .reg_sel     (reg_sel),
        .reg_address (reg_address),
        .reg_wdata   (reg_wdata),
        .reg_we      (reg_we),
        .reg_rdata   (reg_rdata)
`ifdef BUS_ROUTER_FAULT_EN
        ,
        .fault_clear (fault_clear),
        .fault       (fault),
        .fault_addr  (fault_addr)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One access; latency counts negedges from the request cycle to cpu_ready.
    task automatic access(input logic [AW-1:0] a, input logic w, input logic [7:0] d,
                          output int lat, output logic [7:0] rd, output logic [3:0] sel,
                          output logic [3:0] we_or, output int we_cnt);
        @(negedge clock);
        cpu_req     = 1'b1;
        cpu_address = a;
        cpu_we      = w;
        cpu_wdata   = d;
        lat    = 0;
        we_or  = '0;
        we_cnt = 0;
        do begin
            @(negedge clock);
            if (lat == 0) cpu_req = 1'b0;
            lat++;
            if (reg_we != '0) begin
                we_cnt++;
                we_or = we_or | reg_we;
            end
        end while (!cpu_ready && lat < 40);
        rd  = cpu_rdata;
        sel = reg_sel;
    endtask

    int         lat;
    int         we_cnt;
    int         cnt;
    logic [7:0] rd;
    logic [3:0] sel;
    logic [3:0] we_or;

    initial begin
        reset       = 1'b1;
        cpu_req     = 1'b0;
        cpu_address = '0;
        cpu_we      = 1'b0;
        cpu_wdata   = 8'h00;
        reg_rdata   = {8'hD3, 8'hC2, 8'hB1, 8'h5A};
`ifdef BUS_ROUTER_FAULT_EN
        fault_clear = 1'b0;
`endif
        repeat (2) @(negedge clock);
        check("rst_ready", 32'(cpu_ready), 32'h0);
        check("rst_rdata", 32'(cpu_rdata), 32'h0);
        check("rst_sel", 32'(reg_sel), 32'h0);
        check("rst_we", 32'(reg_we), 32'h0);
        check("rst_addr", 32'(reg_address), 32'h0);
        check("rst_wdata", 32'(reg_wdata), 32'h0);
`ifdef BUS_ROUTER_FAULT_EN
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_fault_addr", 32'(fault_addr), 32'h0);
`endif
        reset = 1'b0;

        // Region 0 read, no wait states
        access(20'h12345, 1'b0, 8'h00, lat, rd, sel, we_or, we_cnt);
        check("r0_lat", 32'(lat), 32'd2);
        check("r0_rdata", 32'(rd), 32'h5A);
        check("r0_sel", 32'(sel), 32'b0001);
        check("r0_we_cnt", 32'(we_cnt), 32'd0);
        check("r0_addr", 32'(reg_address), 32'h12345);

        // Region 2 write with 3 wait states
        access(20'h40010, 1'b1, 8'h55, lat, rd, sel, we_or, we_cnt);
        check("r2w_lat", 32'(lat), 32'd5);
        check("r2w_we_cnt", 32'(we_cnt), 32'd1);
        check("r2w_we_bits", 32'(we_or), 32'b0100);
        check("r2w_wdata", 32'(reg_wdata), 32'h55);
        check("r2w_sel", 32'(sel), 32'b0100);
        check("r2w_rdata", 32'(rd), 32'hFF);

        // Region 2 read
        access(20'h7FFFF, 1'b0, 8'h00, lat, rd, sel, we_or, we_cnt);
        check("r2r_lat", 32'(lat), 32'd5);
        check("r2r_rdata", 32'(rd), 32'hC2);
        check("r2r_we_cnt", 32'(we_cnt), 32'd0);

        // Unmapped read
        access(20'h80000, 1'b0, 8'h00, lat, rd, sel, we_or, we_cnt);
        check("um_lat", 32'(lat), 32'd2);
        check("um_rdata", 32'(rd), 32'hFF);
        check("um_sel", 32'(sel), 32'b0000);
        check("um_we_cnt", 32'(we_cnt), 32'd0);
`ifdef BUS_ROUTER_FAULT_EN
        check("um_fault", 32'(fault), 32'h1);
        check("um_fault_addr", 32'(fault_addr), 32'h80000);
`endif

        // Write to read-only region 3
        access(20'hC0004, 1'b1, 8'h77, lat, rd, sel, we_or, we_cnt);
        check("ro_lat", 32'(lat), 32'd3);
        check("ro_we_cnt", 32'(we_cnt), 32'd0);
        check("ro_sel", 32'(sel), 32'b1000);
`ifdef BUS_ROUTER_FAULT_EN
        check("ro_fault", 32'(fault), 32'h1);
        check("ro_fault_addr_first", 32'(fault_addr), 32'h80000);
`endif

        // Region 3 read is still allowed
        access(20'hFFFFF, 1'b0, 8'h00, lat, rd, sel, we_or, we_cnt);
        check("r3r_lat", 32'(lat), 32'd3);
        check("r3r_rdata", 32'(rd), 32'hD3);

        // Overlap of r0 and r1: lowest index wins
        access(20'h00010, 1'b0, 8'h00, lat, rd, sel, we_or, we_cnt);
        check("ovl_sel", 32'(sel), 32'b0001);
        check("ovl_rdata", 32'(rd), 32'h5A);
        check("ovl_lat", 32'(lat), 32'd2);

        // Region 1 reachable above r0's window is impossible; hit r1-only via r0 miss? no: check r0 write strobe
        access(20'h3FF00, 1'b1, 8'hA5, lat, rd, sel, we_or, we_cnt);
        check("r0w_we_bits", 32'(we_or), 32'b0001);
        check("r0w_lat", 32'(lat), 32'd2);

        // Extra request during WAIT is ignored
        @(negedge clock);
        cpu_req     = 1'b1;
        cpu_address = 20'h40020;
        cpu_we      = 1'b0;
        cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            if (cpu_ready) cnt++;
            if (c == 1) cpu_req = 1'b0;
            if (c == 2) begin
                cpu_req     = 1'b1;
                cpu_address = 20'h00001;
            end
            if (c == 3) cpu_req = 1'b0;
        end
        check("xreq_ready_cnt", 32'(cnt), 32'd1);
        check("xreq_addr", 32'(reg_address), 32'h40020);
        check("xreq_sel", 32'(reg_sel), 32'b0100);
        check("xreq_rdata", 32'(cpu_rdata), 32'hC2);

        // Reset during WAIT aborts the access
        @(negedge clock);
        cpu_req     = 1'b1;
        cpu_address = 20'h40030;
        cpu_we      = 1'b1;
        cpu_wdata   = 8'h99;
        cnt = 0;
        @(negedge clock);
        cpu_req = 1'b0;
        if (cpu_ready || reg_we != '0) cnt++;
        @(negedge clock);
        if (cpu_ready || reg_we != '0) cnt++;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (cpu_ready || reg_we != '0) cnt++;
        end
        check("rstw_no_pulse", 32'(cnt), 32'd0);
        check("rstw_sel", 32'(reg_sel), 32'h0);
        check("rstw_addr", 32'(reg_address), 32'h0);
        access(20'h00020, 1'b0, 8'h00, lat, rd, sel, we_or, we_cnt);
        check("rstw_idle_lat", 32'(lat), 32'd2);
        check("rstw_idle_rdata", 32'(rd), 32'h5A);

`ifdef BUS_ROUTER_FAULT_EN
        // Sticky capture, clear, and event-beats-clear
        access(20'h90000, 1'b0, 8'h00, lat, rd, sel, we_or, we_cnt);
        check("f_set", 32'(fault), 32'h1);
        check("f_set_addr", 32'(fault_addr), 32'h90000);
        @(negedge clock);
        fault_clear = 1'b1;
        @(negedge clock);
        fault_clear = 1'b0;
        check("f_clr", 32'(fault), 32'h0);
        check("f_clr_addr", 32'(fault_addr), 32'h0);
        access(20'h90004, 1'b0, 8'h00, lat, rd, sel, we_or, we_cnt);
        @(negedge clock);
        cpu_req     = 1'b1;
        cpu_address = 20'hA0000;
        cpu_we      = 1'b0;
        fault_clear = 1'b1;
        @(negedge clock);
        cpu_req     = 1'b0;
        fault_clear = 1'b0;
        check("f_win", 32'(fault), 32'h1);
        check("f_win_addr", 32'(fault_addr), 32'hA0000);
        repeat (3) @(negedge clock);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
